// File: rtl/mem_responder.sv
// mem_responder: load/store lane steering and two-cycle load response for a RAM port
module mem_responder (
  input  logic        CLK,
  input  logic        RST,
  input  logic        mem_en,
  input  logic [1:0]  store_size,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);
  typedef enum logic {IDLE, LOAD_RESP} state_t;
  state_t state, state_nxt;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic lmis_q, mis_q, is_load, accept, half_acc, word_acc, mis_now;
  logic [3:0] we;
  logic [7:0] b;
  logic [15:0] h;
  // state and captured load context; a misaligned request raises the flag for the following cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      f3_q   <= '0;
      off_q  <= '0;
      lmis_q <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      mis_q <= accept & mis_now;
      if (accept & is_load) begin
        f3_q   <= funct3;
        off_q  <= addr[1:0];
        lmis_q <= mis_now;
      end
    end
  end
  // request decode, RAM drive, next state and load extraction
  always_comb begin
    is_load    = store_size == 2'b11;
    half_acc   = is_load ? funct3[1:0] == 2'b01 : store_size == 2'b01;
    word_acc   = is_load ? funct3 == 3'b010 : store_size == 2'b10;
    mis_now    = (half_acc & addr[0]) | (word_acc & |addr[1:0]);
    accept     = state == IDLE & mem_en & ~RST;
    state_nxt  = (accept & is_load) ? LOAD_RESP : IDLE;
    ram_en     = accept & ~mis_now;
    we         = store_size == 2'b00 ? 4'b0001 << addr[1:0] :
                 store_size == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    ram_we     = (ram_en & ~is_load) ? we : 4'b0000;
    ram_wdata  = store_size == 2'b00 ? {4{wdata[7:0]}} :
                 store_size == 2'b01 ? {2{wdata[15:0]}} : wdata;
    ram_addr   = addr[31:2];
    load_valid = state == LOAD_RESP & ~RST;
    misaligned = mis_q & ~RST;
    b          = ram_rdata[{off_q, 3'b000} +: 8];
    h          = ram_rdata[{off_q[1], 4'b0000} +: 16];
    load_data  = (~load_valid | lmis_q) ? 32'h0 :
                 f3_q == 3'b000 ? {{24{b[7]}}, b} :
                 f3_q == 3'b001 ? {{16{h[15]}}, h} :
                 f3_q == 3'b010 ? ram_rdata :
                 f3_q == 3'b100 ? {24'h0, b} :
                 f3_q == 3'b101 ? {16'h0, h} : 32'h0;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of store steering, load extraction, misalignment and reset
module tb_mem_responder;
  logic CLK = 1'b0, RST, mem_en;
  logic [1:0] store_size;
  logic [2:0] funct3;
  logic [31:0] addr, wdata, ram_rdata, load_data, ram_wdata;
  logic load_valid, misaligned, ram_en;
  logic [3:0] ram_we;
  logic [29:0] ram_addr;
  int checks = 0, errors = 0;

  mem_responder dut (
    .CLK(CLK), .RST(RST), .mem_en(mem_en), .store_size(store_size), .funct3(funct3),
    .addr(addr), .wdata(wdata), .load_data(load_data), .load_valid(load_valid),
    .misaligned(misaligned), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic req(input logic en, input logic [1:0] sz, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d);
    mem_en = en; store_size = sz; funct3 = f3; addr = a; wdata = d;
    #1;
  endtask

  task automatic do_store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input logic en_exp, input logic [3:0] we_exp,
                          input logic [31:0] wd_exp);
    req(1'b1, sz, 3'b000, a, d);
    chk({tag, "_en"}, {31'h0, ram_en}, {31'h0, en_exp});
    chk({tag, "_we"}, {28'h0, ram_we}, {28'h0, we_exp});
    chk({tag, "_addr"}, {2'b00, ram_addr}, {2'b00, a[31:2]});
    if (en_exp) chk({tag, "_wdata"}, ram_wdata, wd_exp);
    tick();
    req(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    chk({tag, "_lv"}, {31'h0, load_valid}, 32'h0);
    chk({tag, "_mis"}, {31'h0, misaligned}, {31'h0, ~en_exp});
    tick();
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic en_exp, input logic [31:0] ld_exp);
    req(1'b1, 2'b11, f3, a, 32'h0);
    chk({tag, "_en"}, {31'h0, ram_en}, {31'h0, en_exp});
    chk({tag, "_we"}, {28'h0, ram_we}, 32'h0);
    tick();
    req(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    ram_rdata = rd;
    #1;
    chk({tag, "_lv"}, {31'h0, load_valid}, 32'h1);
    chk({tag, "_data"}, load_data, ld_exp);
    chk({tag, "_mis"}, {31'h0, misaligned}, {31'h0, ~en_exp});
    tick();
    chk({tag, "_lv_off"}, {31'h0, load_valid}, 32'h0);
    chk({tag, "_data_off"}, load_data, 32'h0);
  endtask

  initial begin
    RST = 1'b1; ram_rdata = 32'hDEAD_BEEF;
    req(1'b1, 2'b11, 3'b010, 32'h0, 32'h0);
    tick();
    tick();
    chk("rst_en", {31'h0, ram_en}, 32'h0);
    chk("rst_we", {28'h0, ram_we}, 32'h0);
    chk("rst_lv", {31'h0, load_valid}, 32'h0);
    chk("rst_mis", {31'h0, misaligned}, 32'h0);
    RST = 1'b0;
    do_store("sb", 2'b00, 32'h0000_0103, 32'h0000_00AB, 1'b1, 4'b1000, 32'hABAB_ABAB);
    do_store("sh", 2'b01, 32'h0000_0202, 32'h1234_BEEF, 1'b1, 4'b1100, 32'hBEEF_BEEF);
    do_store("sh0", 2'b01, 32'h0000_0200, 32'h1234_BEEF, 1'b1, 4'b0011, 32'hBEEF_BEEF);
    do_store("sw", 2'b10, 32'h0000_0010, 32'hCAFE_F00D, 1'b1, 4'b1111, 32'hCAFE_F00D);
    do_store("sw_mis", 2'b10, 32'h0000_0102, 32'hCAFE_F00D, 1'b0, 4'b0000, 32'h0);
    do_store("sh_mis", 2'b01, 32'h0000_0101, 32'h1234_5678, 1'b0, 4'b0000, 32'h0);
    chk("mis_clear", {31'h0, misaligned}, 32'h0);
    do_load("lb", 3'b000, 32'h0000_0003, 32'h80FF_7F01, 1'b1, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h0000_0003, 32'h80FF_7F01, 1'b1, 32'h0000_0080);
    do_load("lb1", 3'b000, 32'h0000_0001, 32'h80FF_7F01, 1'b1, 32'h0000_007F);
    do_load("lh", 3'b001, 32'h0000_0002, 32'h8001_1234, 1'b1, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h0000_0002, 32'h8001_1234, 1'b1, 32'h0000_8001);
    do_load("lh0", 3'b001, 32'h0000_0000, 32'h8001_1234, 1'b1, 32'h0000_1234);
    do_load("lw", 3'b010, 32'h0000_0004, 32'h1234_5678, 1'b1, 32'h1234_5678);
    do_load("bad_f3", 3'b011, 32'h0000_0000, 32'h1234_5678, 1'b1, 32'h0);
    do_load("lh_mis", 3'b001, 32'h0000_0001, 32'h8001_1234, 1'b0, 32'h0);
    do_load("lw_mis", 3'b010, 32'h0000_0006, 32'h8001_1234, 1'b0, 32'h0);
    req(1'b1, 2'b11, 3'b010, 32'h0000_0004, 32'h0);
    chk("b2b_lw_en", {31'h0, ram_en}, 32'h1);
    tick();
    ram_rdata = 32'h0BAD_F00D;
    #1;
    chk("b2b_ign_en", {31'h0, ram_en}, 32'h0);
    chk("b2b_ign_lv", {31'h0, load_valid}, 32'h1);
    chk("b2b_ign_data", load_data, 32'h0BAD_F00D);
    tick();
    req(1'b1, 2'b10, 3'b000, 32'h0000_0008, 32'h5555_AAAA);
    chk("b2b_sw_en", {31'h0, ram_en}, 32'h1);
    chk("b2b_sw_we", {28'h0, ram_we}, 32'hF);
    chk("b2b_sw_lv", {31'h0, load_valid}, 32'h0);
    tick();
    req(1'b1, 2'b11, 3'b010, 32'h0000_0004, 32'h0);
    chk("rml_en", {31'h0, ram_en}, 32'h1);
    tick();
    req(1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("rml_lv", {31'h0, load_valid}, 32'h0);
    chk("rml_data", load_data, 32'h0);
    chk("rml_en_after", {31'h0, ram_en}, 32'h0);
    do_store("post_rst_sb", 2'b00, 32'h0000_0001, 32'h0000_0011, 1'b1, 4'b0010, 32'h1111_1111);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
